// File: rtl/switch_rr_arbiter_if.sv
// Switch-to-LED bundle between the raw board pins and the round-robin arbiter.
// The arbiter takes the slave side. Whatever drives the switches takes the master side.
interface switch_rr_arbiter_if;
  logic i_Switch_1;
  logic i_Switch_2;
  logic i_Switch_3;
  logic i_Switch_4;
  logic o_LED_1;
  logic o_LED_2;
  logic o_LED_3;
  logic o_LED_4;
  logic o_Busy;

  modport master (
    output i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
    input  o_LED_1, o_LED_2, o_LED_3, o_LED_4, o_Busy
  );

  modport slave (
    input  i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
    output o_LED_1, o_LED_2, o_LED_3, o_LED_4, o_Busy
  );
endinterface

// File: rtl/switch_rr_arbiter.sv
// Debounces four board switches and grants one LED at a time in round-robin order.
// Under contention each grant lasts exactly HOLD_CYCLES. Releasing a grant always passes through one idle cycle.
module switch_rr_arbiter #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES     = 12500000,
  parameter int CNT_W           = 24
) (
  input logic               i_Clk,
  input logic               i_Rst,
  switch_rr_arbiter_if.slave sw_bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [3:0]       raw;
  logic [3:0]       sync_a;
  logic [3:0]       sync_b;
  logic [3:0]       req;
  logic [CNT_W-1:0] deb_cnt [4];

  state_t           state_q;
  state_t           state_d;
  logic [3:0]       grant_q;
  logic [3:0]       grant_d;
  logic [1:0]       grant_idx_q;
  logic [1:0]       grant_idx_d;
  logic [1:0]       last_grant_q;
  logic [1:0]       last_grant_d;
  logic [CNT_W-1:0] hold_q;
  logic [CNT_W-1:0] hold_d;

  logic [3:0]       others;
  logic [1:0]       pick_idle;
  logic [1:0]       pick_rot;

  assign raw = {sw_bus.i_Switch_4, sw_bus.i_Switch_3, sw_bus.i_Switch_2, sw_bus.i_Switch_1};

  // Returns the first set bit of r, searching from last+1 round to last itself.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    logic [1:0] result;
    found  = 1'b0;
    result = last + 2'd1;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && r[idx]) begin
        result = idx;
        found  = 1'b1;
      end
    end
    return result;
  endfunction

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      req <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync_b[i] == req[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] >= DEB_LAST) begin
          req[i]     <= sync_b[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      grant_idx_q  <= '0;
      last_grant_q <= 2'd3;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
      hold_q       <= hold_d;
    end
  end

  assign others    = req & ~grant_q;
  assign pick_idle = rr_pick(req, last_grant_q);
  assign pick_rot  = rr_pick(others, grant_idx_q);

  // The release check comes first, so a requester that drops as its hold expires goes back through IDLE.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    hold_d       = hold_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (|req) begin
          grant_idx_d = pick_idle;
          grant_d     = 4'(1) << pick_idle;
          hold_d      = HOLD_LAST;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (!req[grant_idx_q]) begin
          grant_d      = '0;
          last_grant_d = grant_idx_q;
          hold_d       = '0;
          state_d      = IDLE;
        end else if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else if (|others) begin
          grant_idx_d  = pick_rot;
          grant_d      = 4'(1) << pick_rot;
          last_grant_d = grant_idx_q;
          hold_d       = HOLD_LAST;
        end else begin
          hold_d = '0;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    sw_bus.o_LED_1 = grant_q[0];
    sw_bus.o_LED_2 = grant_q[1];
    sw_bus.o_LED_3 = grant_q[2];
    sw_bus.o_LED_4 = grant_q[3];
    sw_bus.o_Busy  = (state_q == GRANT);
  end

endmodule

// File: tb/tb_switch_rr_arbiter.sv
// Directed bench for switch_rr_arbiter with DEBOUNCE_CYCLES=4 and HOLD_CYCLES=8.
// From a switch change to a visible LED rise there are 2 sync edges, 4 debounce edges and 1 grant edge.
module tb_switch_rr_arbiter;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  switch_rr_arbiter_if bus ();

  switch_rr_arbiter #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(8),
    .CNT_W(24)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .sw_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [3:0] sw);
    bus.i_Switch_1 = sw[0];
    bus.i_Switch_2 = sw[1];
    bus.i_Switch_3 = sw[2];
    bus.i_Switch_4 = sw[3];
  endtask

  // The expected value is {LED_4, LED_3, LED_2, LED_1, Busy}.
  task automatic check_output(input string tag, input logic [4:0] expected);
    logic [4:0] observed;
    observed = {bus.o_LED_4, bus.o_LED_3, bus.o_LED_2, bus.o_LED_1, bus.o_Busy};
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset is asserted while all four switches are high.
    rst = 1'b1;
    apply_stimulus(4'b1111);
    tick(); tick(); tick();
    check_output("reset_outputs", 5'b0000_0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_output($sformatf("reset_settle_%0d", i), 5'b0000_0);
    end
    tick();
    check_output("all_first_grant_led1", 5'b0001_1);

    // All four switches stay high, so the grant rotates 1,2,3,4,1 with 8 cycles per grant.
    for (int k = 1; k < 40; k++) begin
      tick();
      check_output($sformatf("all_rotate_%0d", k), {4'(4'(1) << ((k / 8) % 4)), 1'b1});
    end

    // Reset is pulsed asynchronously in the middle of a clock period.
    #2 rst = 1'b1;
    #1 check_output("async_reset_mid_grant", 5'b0000_0);
    apply_stimulus(4'b0101);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_output($sformatf("pair_settle_%0d", i), 5'b0000_0);
    end
    tick();
    check_output("pair_first_led1", 5'b0001_1);
    for (int k = 1; k < 24; k++) begin
      tick();
      check_output($sformatf("pair_rotate_%0d", k),
                   ((k / 8) == 1) ? 5'b0100_1 : 5'b0001_1);
    end

    // Switch 2 bounces, and no request may form during the bounce.
    rst = 1'b1;
    apply_stimulus(4'b0000);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output($sformatf("quiet_%0d", i), 5'b0000_0);
    end
    for (int i = 0; i < 6; i++) begin
      apply_stimulus({2'b00, (i % 2 == 0), 1'b0});
      tick();
      check_output($sformatf("bounce_%0d", i), 5'b0000_0);
    end
    apply_stimulus(4'b0010);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_output($sformatf("bounce_settle_%0d", i), 5'b0000_0);
    end
    tick();
    check_output("bounce_grant_led2", 5'b0010_1);

    // Switch 2 releases while switch 4 starts waiting. One idle cycle comes before LED_4.
    apply_stimulus(4'b1000);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_output($sformatf("release_hold_led2_%0d", i), 5'b0010_1);
    end
    tick();
    check_output("release_idle_gap", 5'b0000_0);
    tick();
    check_output("release_grant_led4", 5'b1000_1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
